seg_mux_display: RTL and testbench

SEG_MUX_DISPLAY -- requirements
Module: seg_mux_display

---
 rtl/seg_mux_display.sv | 142 ++++++++++++++
 tb/tb_seg_mux_display.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seg_mux_display.sv
// Multiplexed seven-segment display driver: scans DIGITS digits, frame-synchronous
// shadowing of display data, leading-zero blanking and per-digit blink.
module seg_mux_display #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 32,
  parameter int LZ_BLANK  = 1
) (
  input  logic                  dp_clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   nums,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  load,
  output logic [6:0]            cats,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     anodes,
  output logic                  frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CW-1:0]         pre_cnt;
  logic [IW-1:0]         dig_idx;
  logic [FW-1:0]         frm_cnt;
  logic                  blink_phase;
  logic                  tick;
  logic                  wrap_tick;

  logic [4*DIGITS-1:0]   pend_nums;
  logic [DIGITS-1:0]     pend_dp;
  logic [DIGITS-1:0]     pend_blink;
  logic [4*DIGITS-1:0]   sh_nums;
  logic [DIGITS-1:0]     sh_dp;
  logic [DIGITS-1:0]     sh_blink;

  logic [DIGITS-1:0]     lz_blank;
  logic                  lz_run;
  logic [3:0]            cur_val;
  logic                  cur_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

  assign tick      = (pre_cnt == CW'(SCAN_DIV - 1));
  assign wrap_tick = tick && (dig_idx == IW'(DIGITS - 1));

  always_ff @(posedge dp_clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt     <= '0;
      dig_idx     <= '0;
      frm_cnt     <= '0;
      blink_phase <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= wrap_tick;
      if (tick) begin
        pre_cnt <= '0;
        dig_idx <= wrap_tick ? '0 : dig_idx + IW'(1);
      end else begin
        pre_cnt <= pre_cnt + CW'(1);
      end
      if (wrap_tick) begin
        if (frm_cnt == FW'(BLINK_DIV - 1)) begin
          frm_cnt     <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frm_cnt <= frm_cnt + FW'(1);
        end
      end
    end
  end

  // A load coinciding with the wrap tick bypasses pending so it lands this boundary.
  always_ff @(posedge dp_clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_nums  <= '0;
      pend_dp    <= '0;
      pend_blink <= '0;
      sh_nums    <= '0;
      sh_dp      <= '0;
      sh_blink   <= '0;
    end else begin
      if (load) begin
        pend_nums  <= nums;
        pend_dp    <= dp_in;
        pend_blink <= blink_mask;
      end
      if (wrap_tick) begin
        sh_nums  <= load ? nums       : pend_nums;
        sh_dp    <= load ? dp_in      : pend_dp;
        sh_blink <= load ? blink_mask : pend_blink;
      end
    end
  end

  always_comb begin
    lz_blank = '0;
    lz_run   = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_run = lz_run && (sh_nums[4*i +: 4] == 4'h0) && !sh_dp[i];
      lz_blank[i] = (LZ_BLANK != 0) && (i > 0) && lz_run;
    end
  end

  // Outputs latch the digit whose slot is ending, so digit 0 is first shown after the first tick.
  assign cur_val   = sh_nums[{dig_idx, 2'b00} +: 4];
  assign cur_blank = lz_blank[dig_idx] || (blink_phase && sh_blink[dig_idx]);

  always_ff @(posedge dp_clk or negedge rst_n) begin
    if (!rst_n) begin
      anodes <= '1;
      cats   <= 7'b1111111;
      dp_n   <= 1'b1;
    end else if (tick) begin
      anodes <= ~(DIGITS'(1) << dig_idx);
      cats   <= cur_blank ? 7'b1111111 : seg_decode(cur_val);
      dp_n   <= cur_blank ? 1'b1 : ~sh_dp[dig_idx];
    end
  end

endmodule

// File: tb/tb_seg_mux_display.sv
// Bench for seg_mux_display: directed and random loads compared every cycle
// against a slot/frame arithmetic reference model.
module tb_seg_mux_display;
  localparam int D = 4;
  localparam int S = 4;
  localparam int B = 2;

  logic          dp_clk = 1'b0;
  logic          rst_n;
  logic [15:0]   nums;
  logic [3:0]    dp_in;
  logic [3:0]    blink_mask;
  logic          load;
  logic [6:0]    cats;
  logic          dp_n;
  logic [3:0]    anodes;
  logic          frame_done;

  seg_mux_display #(.DIGITS(D), .SCAN_DIV(S), .BLINK_DIV(B), .LZ_BLANK(1)) dut (
    .dp_clk(dp_clk), .rst_n(rst_n), .nums(nums), .dp_in(dp_in),
    .blink_mask(blink_mask), .load(load), .cats(cats), .dp_n(dp_n),
    .anodes(anodes), .frame_done(frame_done)
  );

  always #5 dp_clk = ~dp_clk;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  int fd_seen;
  logic [15:0] p_nums, s_nums;
  logic [3:0]  p_dp, s_dp, p_bl, s_bl;
  logic [3:0]  exp_an;
  logic [6:0]  exp_cats;
  logic        exp_dp, exp_fd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  function automatic void model_reset();
    cyc = 0;
    p_nums = '0; s_nums = '0; p_dp = '0; s_dp = '0; p_bl = '0; s_bl = '0;
    exp_an = 4'hF; exp_cats = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
  endfunction

  // Leading-zero rule: digit d>0 is blank when it and all higher digits are 0 with no dp.
  function automatic bit lz_blank(input int d);
    if (d == 0) return 0;
    for (int j = d; j < D; j++)
      if (s_nums[4*j +: 4] != 4'h0 || s_dp[j]) return 0;
    return 1;
  endfunction

  function automatic void model_edge();
    int  t, d;
    bit  tick, wrap, phase, blank;
    tick = (cyc % S) == S - 1;
    t    = cyc / S;
    d    = t % D;
    wrap = tick && (d == D - 1);
    exp_fd = wrap;
    if (tick) begin
      phase    = ((t / D) / B) % 2;
      blank    = (phase && s_bl[d]) || lz_blank(d);
      exp_an   = ~(4'b0001 << d);
      exp_cats = blank ? 7'h7F : seg_tab[s_nums[4*d +: 4]];
      exp_dp   = blank ? 1'b1 : ~s_dp[d];
    end
    if (wrap) begin
      s_nums = load ? nums : p_nums;
      s_dp   = load ? dp_in : p_dp;
      s_bl   = load ? blink_mask : p_bl;
    end
    if (load) begin
      p_nums = nums; p_dp = dp_in; p_bl = blink_mask;
    end
    cyc++;
  endfunction

  task automatic check_outputs();
    chk("anodes", 32'(anodes), 32'(exp_an));
    chk("cats", 32'(cats), 32'(exp_cats));
    chk("dp_n", 32'(dp_n), 32'(exp_dp));
    chk("frame_done", 32'(frame_done), 32'(exp_fd));
  endtask

  task automatic step();
    @(posedge dp_clk);
    if (rst_n) model_edge();
    #1;
    check_outputs();
    if (frame_done) fd_seen++;
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] n, input logic [3:0] dp, input logic [3:0] bl);
    nums = n; dp_in = dp; blink_mask = bl; load = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; nums = '0; dp_in = '0; blink_mask = '0; load = 1'b0;
    model_reset();
    fd_seen = 0;
    run(3);

    #1 rst_n = 1'b1;
    do_load(16'h1234, 4'b0000, 4'b0000);
    run(48);

    do_load(16'h0070, 4'b0000, 4'b0000);
    run(32);
    do_load(16'h0070, 4'b0100, 4'b0000);
    run(32);

    do_load(16'h8888, 4'b0000, 4'b0001);
    run(160);

    // two loads mid-frame: only the later one should reach the display
    while ((cyc % 16) != 5) step();
    do_load(16'h1111, 4'b0000, 4'b0000);
    run(3);
    do_load(16'h2222, 4'b0000, 4'b0000);
    run(40);

    // load exactly on the wrap tick
    while ((cyc % 16) != 15) step();
    do_load(16'h5A5A, 4'b1000, 4'b0000);
    run(32);

    fd_seen = 0;
    run(64);
    chk("frame_done_count", 32'(fd_seen), 32'd4);

    // asynchronous reset in the middle of a frame
    while ((cyc % 16) != 9) step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    run(3);
    #1 rst_n = 1'b1;
    run(48);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        logic [15:0] r;
        for (int j = 0; j < 4; j++)
          r[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        nums = r;
        dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        blink_mask = 4'($urandom);
        load = 1'b1;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
